// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl: coin-operated washing-machine sequencer.
// Accumulates coin credit, launches one of NUM_MODES programmes (mode k costs
// k+1 coins), times the soak/wash/rinse/spin phases internally, supports
// pause / lid interlock, sticky errors, and refunds remaining credit on cancel.
module wash_cycle_ctrl #(
    parameter int NUM_MODES = 3,
    parameter int CREDIT_W  = 4,
    parameter int TIMER_W   = 16,
    parameter int SOAK_CYC  = 100,
    parameter int WASH_CYC  = 200,
    parameter int RINSE_CYC = 100,
    parameter int SPIN_CYC  = 50,
    localparam int MODE_W   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin,
    input  logic [NUM_MODES-1:0] mode_sel,
    input  logic                 start,
    input  logic                 cancel,
    input  logic                 pause,
    input  logic                 lid_open,
    output logic                 idle,
    output logic                 ready,
    output logic                 soak,
    output logic                 wash,
    output logic                 rinse,
    output logic                 spin,
    output logic                 paused,
    output logic                 done,
    output logic                 error,
    output logic                 coin_rtrn,
    output logic                 coin_rej,
    output logic [CREDIT_W-1:0]  credit,
    output logic [MODE_W-1:0]    mode_q,
    output logic [TIMER_W-1:0]   time_left
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_READY  = 4'd1,
        S_SOAK   = 4'd2,
        S_WASH   = 4'd3,
        S_RINSE  = 4'd4,
        S_SPIN   = 4'd5,
        S_PAUSE  = 4'd6,
        S_DONE   = 4'd7,
        S_ERROR  = 4'd8,
        S_REFUND = 4'd9
    } state_t;

    localparam logic [CREDIT_W-1:0] CMAX = '1;

    state_t               state, state_nxt;
    state_t               saved, saved_nxt;
    logic [CREDIT_W-1:0]  credit_nxt;
    logic [MODE_W-1:0]    mode_nxt;
    logic [TIMER_W-1:0]   time_nxt;
    logic                 coin_ok;
    logic [31:0]          sel_count;
    logic [MODE_W-1:0]    sel_idx;
    state_t               adv;
    state_t               first_phase;

    // Countdown reload value (duration - 1) for a phase; wash scales with the mode.
    function automatic logic [TIMER_W-1:0] phase_load(input state_t ph,
                                                       input logic [MODE_W-1:0] m);
        logic [31:0] d;
        case (ph)
            S_SOAK:  d = 32'(SOAK_CYC);
            S_WASH:  d = 32'(WASH_CYC) * (32'(m) + 32'd1);
            S_RINSE: d = 32'(RINSE_CYC);
            S_SPIN:  d = 32'(SPIN_CYC);
            default: d = 32'd1;
        endcase
        d = d - 32'd1;
        return d[TIMER_W-1:0];
    endfunction

    // Phase that follows a running phase once its countdown expires.
    function automatic state_t next_phase(input state_t ph);
        case (ph)
            S_SOAK:  return S_WASH;
            S_WASH:  return S_RINSE;
            S_RINSE: return S_SPIN;
            default: return S_DONE;
        endcase
    endfunction

    // Coins beyond a full credit counter bounce straight back to the customer.
    assign coin_rej = coin && (credit == CMAX);
    assign coin_ok  = coin && (credit != CMAX);

    // Sequential state: controller state, saved phase, credit, mode and timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            saved     <= S_IDLE;
            credit    <= '0;
            mode_q    <= '0;
            time_left <= '0;
        end else begin
            state     <= state_nxt;
            saved     <= saved_nxt;
            credit    <= credit_nxt;
            mode_q    <= mode_nxt;
            time_left <= time_nxt;
        end
    end

    // Next-state logic including credit accounting and phase countdown.
    always_comb begin
        state_nxt   = state;
        saved_nxt   = saved;
        credit_nxt  = credit + CREDIT_W'(coin_ok);
        mode_nxt    = mode_q;
        time_nxt    = time_left;
        sel_count   = 32'd0;
        sel_idx     = '0;
        adv         = next_phase(state);
        first_phase = S_WASH;

        for (int i = 0; i < NUM_MODES; i++) begin
            if (mode_sel[i]) begin
                sel_count = sel_count + 32'd1;
                sel_idx   = MODE_W'(i);
            end
        end

        case (state)
            S_IDLE: begin
                // A coin arriving in the last refund/done cycle still gets a session.
                if (credit_nxt != '0) state_nxt = S_READY;
            end
            S_READY: begin
                if (cancel) begin
                    state_nxt = S_REFUND;
                    time_nxt  = '0;
                end else if (start && !lid_open) begin
                    if (sel_count != 32'd1 ||
                        32'(credit) < (32'(sel_idx) + 32'd1)) begin
                        state_nxt = S_ERROR;
                    end else begin
                        first_phase = (sel_idx == '0) ? S_WASH : S_SOAK;
                        mode_nxt    = sel_idx;
                        credit_nxt  = credit - CREDIT_W'(sel_idx) - CREDIT_W'(1)
                                      + CREDIT_W'(coin_ok);
                        state_nxt   = first_phase;
                        time_nxt    = phase_load(first_phase, sel_idx);
                    end
                end
            end
            S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
                if (cancel) begin
                    state_nxt = S_REFUND;
                    time_nxt  = '0;
                end else if (pause || lid_open) begin
                    state_nxt = S_PAUSE;
                    saved_nxt = state;
                end else if (time_left == '0) begin
                    state_nxt = adv;
                    time_nxt  = (adv == S_DONE) ? '0 : phase_load(adv, mode_q);
                end else begin
                    time_nxt = time_left - TIMER_W'(1);
                end
            end
            S_PAUSE: begin
                if (cancel) begin
                    state_nxt = S_REFUND;
                    time_nxt  = '0;
                end else if (!pause && !lid_open) begin
                    state_nxt = saved;
                end
            end
            S_DONE: begin
                state_nxt = (credit_nxt != '0) ? S_READY : S_IDLE;
            end
            S_ERROR: begin
                if (cancel) begin
                    state_nxt = S_REFUND;
                    time_nxt  = '0;
                end
            end
            S_REFUND: begin
                if (credit != '0) begin
                    credit_nxt = credit - CREDIT_W'(1) + CREDIT_W'(coin_ok);
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore decode of the state indicators and refund pulse.
    always_comb begin
        idle      = 1'b0;
        ready     = 1'b0;
        soak      = 1'b0;
        wash      = 1'b0;
        rinse     = 1'b0;
        spin      = 1'b0;
        paused    = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        coin_rtrn = 1'b0;
        case (state)
            S_IDLE:   idle      = 1'b1;
            S_READY:  ready     = 1'b1;
            S_SOAK:   soak      = 1'b1;
            S_WASH:   wash      = 1'b1;
            S_RINSE:  rinse     = 1'b1;
            S_SPIN:   spin      = 1'b1;
            S_PAUSE:  paused    = 1'b1;
            S_DONE:   done      = 1'b1;
            S_ERROR:  error     = 1'b1;
            S_REFUND: coin_rtrn = (credit != '0);
            default:  idle      = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// tb_wash_cycle_ctrl: directed self-checking bench for wash_cycle_ctrl.
module tb_wash_cycle_ctrl;

    localparam int NUM_MODES = 3;
    localparam int CREDIT_W  = 4;
    localparam int TIMER_W   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 coin;
    logic [NUM_MODES-1:0] mode_sel;
    logic                 start;
    logic                 cancel;
    logic                 pause;
    logic                 lid_open;
    logic                 idle, ready, soak, wash, rinse, spin, paused, done, error;
    logic                 coin_rtrn, coin_rej;
    logic [CREDIT_W-1:0]  credit;
    logic [1:0]           mode_q;
    logic [TIMER_W-1:0]   time_left;

    int total = 0;
    int bad   = 0;

    wash_cycle_ctrl #(
        .NUM_MODES(3), .CREDIT_W(4), .TIMER_W(16),
        .SOAK_CYC(100), .WASH_CYC(200), .RINSE_CYC(100), .SPIN_CYC(50)
    ) dut (
        .clk(clk), .rst(rst), .coin(coin), .mode_sel(mode_sel), .start(start),
        .cancel(cancel), .pause(pause), .lid_open(lid_open),
        .idle(idle), .ready(ready), .soak(soak), .wash(wash), .rinse(rinse),
        .spin(spin), .paused(paused), .done(done), .error(error),
        .coin_rtrn(coin_rtrn), .coin_rej(coin_rej), .credit(credit),
        .mode_q(mode_q), .time_left(time_left)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        coin = 0; mode_sel = '0; start = 0; cancel = 0; pause = 0; lid_open = 0;
        rst = 1;
        tick(2);
        rst = 0;
        tick(1);
    endtask

    task automatic insert_coins(input int n);
        coin = 1;
        tick(n);
        coin = 0;
    endtask

    task automatic press_start(input logic [NUM_MODES-1:0] sel);
        mode_sel = sel;
        start = 1;
        tick(1);
        start = 0;
        mode_sel = '0;
    endtask

    function automatic logic phase_flag(input int which);
        case (which)
            0:       return soak;
            1:       return wash;
            2:       return rinse;
            default: return spin;
        endcase
    endfunction

    // Counts consecutive cycles with the given phase indicator high.
    task automatic measure(input int which, output int cnt);
        cnt = 0;
        while (phase_flag(which) && cnt < 2000) begin
            cnt++;
            tick(1);
        end
    endtask

    task automatic test_reset();
        coin = 0; mode_sel = '0; start = 0; cancel = 0; pause = 0; lid_open = 0;
        rst = 1;
        tick(1);
        total++;
        if ({idle, ready, soak, wash, rinse, spin, paused, done, error, coin_rtrn, coin_rej} !== 11'b100_0000_0000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b expected %b",
                     {idle, ready, soak, wash, rinse, spin, paused, done, error, coin_rtrn, coin_rej}, 11'b100_0000_0000);
        end
        total++;
        if ({credit, mode_q, time_left} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_regs: got credit=%0d mode_q=%0d time_left=%0d expected all 0", credit, mode_q, time_left);
        end
        rst = 0;
        tick(3);
        total++;
        if (idle !== 1'b1 || credit !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_hold_idle: got idle=%b credit=%0d expected idle=1 credit=0", idle, credit);
        end
    endtask

    task automatic test_quick_mode();
        int cnt;
        do_reset();
        insert_coins(1);
        total++;
        if (ready !== 1'b1 || credit !== 4'd1) begin
            bad++;
            $display("[TB] FAIL quick_ready: got ready=%b credit=%0d expected ready=1 credit=1", ready, credit);
        end
        press_start(3'b001);
        total++;
        if (wash !== 1'b1 || soak !== 1'b0 || time_left !== 16'd199 || credit !== 4'd0 || mode_q !== 2'd0) begin
            bad++;
            $display("[TB] FAIL quick_start: got wash=%b soak=%b tl=%0d credit=%0d mode=%0d expected 1 0 199 0 0",
                     wash, soak, time_left, credit, mode_q);
        end
        measure(1, cnt);
        total++;
        if (cnt !== 200) begin bad++; $display("[TB] FAIL quick_wash_len: got %0d expected 200", cnt); end
        measure(2, cnt);
        total++;
        if (cnt !== 100) begin bad++; $display("[TB] FAIL quick_rinse_len: got %0d expected 100", cnt); end
        measure(3, cnt);
        total++;
        if (cnt !== 50) begin bad++; $display("[TB] FAIL quick_spin_len: got %0d expected 50", cnt); end
        total++;
        if (done !== 1'b1) begin bad++; $display("[TB] FAIL quick_done: got %b expected 1", done); end
        tick(1);
        total++;
        if (idle !== 1'b1 || done !== 1'b0 || credit !== 4'd0) begin
            bad++;
            $display("[TB] FAIL quick_end_idle: got idle=%b done=%b credit=%0d expected 1 0 0", idle, done, credit);
        end
    endtask

    task automatic test_full_mode(input int coins);
        int cnt;
        do_reset();
        insert_coins(coins);
        press_start(3'b100);
        total++;
        if (soak !== 1'b1 || time_left !== 16'd99 || mode_q !== 2'd2 || credit !== 4'(coins - 3)) begin
            bad++;
            $display("[TB] FAIL full_start: got soak=%b tl=%0d mode=%0d credit=%0d expected 1 99 2 %0d",
                     soak, time_left, mode_q, credit, coins - 3);
        end
        measure(0, cnt);
        total++;
        if (cnt !== 100) begin bad++; $display("[TB] FAIL full_soak_len: got %0d expected 100", cnt); end
        measure(1, cnt);
        total++;
        if (cnt !== 600) begin bad++; $display("[TB] FAIL full_wash_len: got %0d expected 600", cnt); end
        measure(2, cnt);
        total++;
        if (cnt !== 100) begin bad++; $display("[TB] FAIL full_rinse_len: got %0d expected 100", cnt); end
        measure(3, cnt);
        total++;
        if (cnt !== 50) begin bad++; $display("[TB] FAIL full_spin_len: got %0d expected 50", cnt); end
        total++;
        if (done !== 1'b1) begin bad++; $display("[TB] FAIL full_done: got %b expected 1", done); end
        tick(1);
        total++;
        if (coins == 3) begin
            if (idle !== 1'b1 || credit !== 4'd0) begin
                bad++;
                $display("[TB] FAIL full_after_done: got idle=%b credit=%0d expected idle=1 credit=0", idle, credit);
            end
        end else begin
            if (ready !== 1'b1 || credit !== 4'd1) begin
                bad++;
                $display("[TB] FAIL full_after_done: got ready=%b credit=%0d expected ready=1 credit=1", ready, credit);
            end
        end
    endtask

    // Follows a 4-coin full run: leftover credit buys a quick wash immediately.
    task automatic test_back_to_back();
        press_start(3'b001);
        total++;
        if (wash !== 1'b1 || credit !== 4'd0 || mode_q !== 2'd0 || time_left !== 16'd199) begin
            bad++;
            $display("[TB] FAIL b2b_start: got wash=%b credit=%0d mode=%0d tl=%0d expected 1 0 0 199",
                     wash, credit, mode_q, time_left);
        end
    endtask

    task automatic test_error();
        do_reset();
        insert_coins(1);
        press_start(3'b100);
        total++;
        if (error !== 1'b1 || credit !== 4'd1) begin
            bad++;
            $display("[TB] FAIL err_enter: got error=%b credit=%0d expected 1 1", error, credit);
        end
        press_start(3'b001);
        tick(4);
        total++;
        if (error !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_sticky: got error=%b ready=%b expected 1 0", error, ready);
        end
        cancel = 1;
        tick(1);
        cancel = 0;
        total++;
        if (coin_rtrn !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_refund_pulse: got rtrn=%b error=%b expected 1 0", coin_rtrn, error);
        end
        tick(1);
        total++;
        if (coin_rtrn !== 1'b0 || idle !== 1'b0 || credit !== 4'd0) begin
            bad++;
            $display("[TB] FAIL err_refund_gap: got rtrn=%b idle=%b credit=%0d expected 0 0 0", coin_rtrn, idle, credit);
        end
        tick(1);
        total++;
        if (idle !== 1'b1) begin bad++; $display("[TB] FAIL err_to_idle: got %b expected 1", idle); end
    endtask

    task automatic test_start_guards();
        int cnt;
        do_reset();
        insert_coins(2);
        lid_open = 1;
        press_start(3'b001);
        lid_open = 0;
        total++;
        if (ready !== 1'b1 || credit !== 4'd2) begin
            bad++;
            $display("[TB] FAIL lid_blocks_start: got ready=%b credit=%0d expected 1 2", ready, credit);
        end
        press_start(3'b011);
        total++;
        if (error !== 1'b1 || credit !== 4'd2) begin
            bad++;
            $display("[TB] FAIL multi_hot_error: got error=%b credit=%0d expected 1 2", error, credit);
        end
        cancel = 1;
        tick(1);
        cancel = 0;
        cnt = 0;
        while (coin_rtrn && cnt < 40) begin cnt++; tick(1); end
        tick(1);
        total++;
        if (cnt !== 2 || idle !== 1'b1) begin
            bad++;
            $display("[TB] FAIL guard_refund: got pulses=%0d idle=%b expected 2 1", cnt, idle);
        end
    endtask

    task automatic test_pause();
        int n;
        int cnt;
        do_reset();
        insert_coins(1);
        press_start(3'b001);
        n = 0;
        while (!(wash && time_left == 16'd37) && n < 500) begin n++; tick(1); end
        total++;
        if (wash !== 1'b1 || time_left !== 16'd37) begin
            bad++;
            $display("[TB] FAIL pause_reach_37: got wash=%b tl=%0d expected 1 37", wash, time_left);
        end
        lid_open = 1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (paused === 1'b1 && time_left === 16'd37) cnt++;
        end
        lid_open = 0;
        total++;
        if (cnt !== 10) begin bad++; $display("[TB] FAIL pause_hold: got %0d held cycles expected 10", cnt); end
        tick(1);
        total++;
        if (wash !== 1'b1 || paused !== 1'b0 || time_left !== 16'd37) begin
            bad++;
            $display("[TB] FAIL pause_resume: got wash=%b paused=%b tl=%0d expected 1 0 37", wash, paused, time_left);
        end
        measure(1, cnt);
        total++;
        if (cnt !== 38 || rinse !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pause_remaining: got %0d cycles rinse=%b expected 38 1", cnt, rinse);
        end
        pause = 1;
        tick(1);
        pause = 0;
        total++;
        if (paused !== 1'b1 || time_left !== 16'd99) begin
            bad++;
            $display("[TB] FAIL pause_input: got paused=%b tl=%0d expected 1 99", paused, time_left);
        end
        tick(1);
        total++;
        if (rinse !== 1'b1 || time_left !== 16'd99) begin
            bad++;
            $display("[TB] FAIL pause_input_resume: got rinse=%b tl=%0d expected 1 99", rinse, time_left);
        end
    endtask

    task automatic test_credit_saturation();
        int rej;
        int cnt;
        do_reset();
        rej = 0;
        coin = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (coin_rej === 1'b1) rej = rej + (i == 15 ? 1 : 100);
            tick(1);
        end
        coin = 0;
        #1;
        total++;
        if (credit !== 4'd15 || rej !== 1 || coin_rej !== 1'b0) begin
            bad++;
            $display("[TB] FAIL saturation: got credit=%0d rej_score=%0d rej_now=%b expected 15 1 0", credit, rej, coin_rej);
        end
        cancel = 1;
        tick(1);
        cancel = 0;
        cnt = 0;
        while (coin_rtrn && cnt < 40) begin cnt++; tick(1); end
        total++;
        if (cnt !== 15 || idle !== 1'b0 || credit !== 4'd0) begin
            bad++;
            $display("[TB] FAIL sat_refund: got pulses=%0d idle=%b credit=%0d expected 15 0 0", cnt, idle, credit);
        end
        tick(1);
        total++;
        if (idle !== 1'b1) begin bad++; $display("[TB] FAIL sat_to_idle: got %b expected 1", idle); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        do_reset();
        insert_coins(3);
        press_start(3'b001);
        n = 0;
        while (!rinse && n < 500) begin n++; tick(1); end
        total++;
        if (rinse !== 1'b1 || credit !== 4'd2) begin
            bad++;
            $display("[TB] FAIL midrst_reach: got rinse=%b credit=%0d expected 1 2", rinse, credit);
        end
        rst = 1;
        tick(1);
        total++;
        if (idle !== 1'b1 || rinse !== 1'b0 || credit !== 4'd0 || coin_rtrn !== 1'b0 || time_left !== 16'd0) begin
            bad++;
            $display("[TB] FAIL midrst: got idle=%b rinse=%b credit=%0d rtrn=%b tl=%0d expected 1 0 0 0 0",
                     idle, rinse, credit, coin_rtrn, time_left);
        end
        rst = 0;
        tick(2);
        total++;
        if (idle !== 1'b1 || coin_rtrn !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_after: got idle=%b rtrn=%b expected 1 0", idle, coin_rtrn);
        end
    endtask

    task automatic test_cancel_at_spin_end();
        int n;
        do_reset();
        insert_coins(2);
        press_start(3'b001);
        n = 0;
        while (!(spin && time_left == 16'd0) && n < 1000) begin n++; tick(1); end
        total++;
        if (spin !== 1'b1 || time_left !== 16'd0) begin
            bad++;
            $display("[TB] FAIL spin_end_reach: got spin=%b tl=%0d expected 1 0", spin, time_left);
        end
        cancel = 1;
        tick(1);
        cancel = 0;
        total++;
        if (done !== 1'b0 || idle !== 1'b0 || coin_rtrn !== 1'b1 || credit !== 4'd1) begin
            bad++;
            $display("[TB] FAIL cancel_vs_done: got done=%b idle=%b rtrn=%b credit=%0d expected 0 0 1 1",
                     done, idle, coin_rtrn, credit);
        end
        tick(2);
        total++;
        if (idle !== 1'b1 || credit !== 4'd0) begin
            bad++;
            $display("[TB] FAIL cancel_end_idle: got idle=%b credit=%0d expected 1 0", idle, credit);
        end
    endtask

    // Scenario sequence, with a hard time limit as a backstop.
    initial begin
        test_reset();
        test_quick_mode();
        test_full_mode(3);
        test_full_mode(4);
        test_back_to_back();
        test_error();
        test_start_guards();
        test_pause();
        test_credit_saturation();
        test_reset_mid_run();
        test_cancel_at_spin_end();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL timeout: simulation did not complete within limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/wash_cycle_ctrl.md
# wash_cycle_ctrl

Parametrised coin-operated washing-machine sequencer, the successor to the fixed three-mode controller. It supports NUM_MODES wash programmes with per-mode price, an accumulated coin credit with change refund, and internal phase timers in place of external done strobes. It adds pause/lid-interlock and error recovery, and sits between the coin acceptor/front panel and the motor/valve drivers.

## Interface
- NUM_MODES, 3: number of programmes; mode k (0-based) costs k+1 coins.
- CREDIT_W, 4: credit counter width; CMAX = 2^CREDIT_W-1.
- TIMER_W, 16: phase timer width.
- SOAK_CYC, 100: soak duration in cycles.
- WASH_CYC, 200: base wash duration; mode k washes WASH_CYC*(k+1) cycles.
- RINSE_CYC, 100: rinse duration.
- SPIN_CYC, 50: spin duration. All durations ≥1 and must fit TIMER_W; the worst-case wash length must also fit TIMER_W.
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- coin  in  1  one coin per high cycle.
- mode_sel  in  NUM_MODES  one-hot programme select, sampled with start.
- start  in  1  begin programme.
- cancel  in  1  abort and refund credit.
- pause  in  1  level; hold the current phase while high.
- lid_open  in  1  level; acts as pause in the running phases and blocks start.
- idle, ready, soak, wash, rinse, spin, paused, done, error  out  1 each  one-hot state indicators.
- coin_rtrn  out  1  one cycle high per refunded coin.
- coin_rej  out  1  coin seen while credit == CMAX (coin not counted).
- credit  out  CREDIT_W  current credit.
- mode_q  out  $clog2(NUM_MODES) (min 1)  latched programme.
- time_left  out  TIMER_W  remaining cycles of the current phase.

## Operation
- States: IDLE, READY, SOAK, WASH, RINSE, SPIN, PAUSE, DONE, ERROR, REFUND.
- Coins: in every state, coin increments credit unless credit == CMAX. At CMAX, coin_rej = coin, combinational, and credit is unchanged.
- IDLE: coin → READY with credit = 1.
- READY, priority cancel > start:
  - cancel → REFUND.
  - start with lid_open → ignored.
  - start with a non-one-hot mode_sel → ERROR.
  - start for mode k with credit < k+1 → ERROR.
  - Otherwise: latch mode_q = k, credit -= k+1 (a same-cycle coin adds 1), go to SOAK, or to WASH if k == 0. Quick mode skips soak.
- Phase entry loads time_left = duration-1. Each unpaused cycle, time_left decrements. At time_left == 0, advance SOAK→WASH→RINSE→SPIN→DONE, so each phase lasts exactly its duration.
- In SOAK/WASH/RINSE/SPIN, pause|lid_open → PAUSE. The phase and time_left are frozen there. PAUSE returns to the saved phase when pause and lid_open are both low, and the countdown resumes with the held value.
- cancel in any running phase, PAUSE, or ERROR → REFUND. Cancel has priority over phase advance and pause. Consumed price is not refunded; only the remaining credit is.
- ERROR: sticky until cancel.
- DONE: lasts one cycle (done = 1), then → READY if credit > 0, else IDLE.
- REFUND: each cycle with credit > 0, coin_rtrn = 1 and credit decrements (a same-cycle coin nets 0). The first cycle with credit == 0 → IDLE, with coin_rtrn = 0.
- Unused encodings → IDLE.

## Timing
- Reset: state IDLE, idle = 1, all other flags 0, credit = 0, mode_q = 0, time_left = 0.
- Indicators are decoded from the state register (Moore). coin_rtrn is decoded from state and credit. coin_rej is the only combinational path from an input.
- start → first phase indicator: 1 cycle. Total run for mode k: (k ? SOAK_CYC : 0) + WASH_CYC*(k+1) + RINSE_CYC + SPIN_CYC cycles of phase, plus pause cycles, then 1 cycle of DONE.
- Refund of n coins: n cycles of coin_rtrn, then 1 cycle of REFUND, then IDLE.
- rst mid-operation: immediate IDLE. Credit is lost and no refund is issued.

## Test plan
- 1 coin, start, mode_sel=001 → READY→WASH (no soak), WASH lasts 200 cycles, RINSE 100, SPIN 50, done for 1 cycle, then idle with credit 0.
- 3 coins, start, mode_sel=100 → soak 100, wash 600, rinse 100, spin 50. Second variant: 4 coins, same start → DONE then READY with credit 1.
- 1 coin, start with mode 2 → error=1 sticky. Then cancel → coin_rtrn high 1 cycle, then idle.
- WASH with time_left = 37: lid_open for 10 cycles → paused=1, time_left held at 37. On release, wash resumes and ends exactly 38 cycles later.
- 16 coins with CREDIT_W=4 → credit 15, coin_rej on the 16th coin. Then cancel → 15 coin_rtrn pulses, 1 gap cycle, then idle.
- Assert rst during RINSE with credit 2 → next cycle idle=1, credit=0, no coin_rtrn. Also cancel and time_left==0 in the same cycle during SPIN → REFUND, not DONE.
